// File: rtl/uart_pkg.sv
// Shared UART definitions for the receiver and the future transmitter.
//   uart_state_t     : receiver FSM states
//   DATA_BITS        : payload bits per frame
//   CLKS_PER_BIT_DEF : default bit period in clk cycles (100 MHz / 115200)
package uart_pkg;

    localparam int unsigned DATA_BITS        = 8;
    localparam int unsigned CLKS_PER_BIT_DEF = 868;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchroniser for an asynchronous input.
//   clk : destination clock
//   rst : synchronous, active-high reset (both flops reset to 1)
//   d   : asynchronous input
//   q   : synchronised output, two clk cycles of latency
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_byte.sv
// UART receiver: 1 start bit, 8 data bits LSB-first, optional parity, 1 stop bit.
//   clk        : system clock
//   rst        : synchronous, active-high reset
//   rx         : raw serial line, asynchronous, idle high
//   data_out   : last accepted byte, held until the next accepted frame
//   rx_done    : one-cycle pulse when data_out is updated
//   parity_err : one-cycle pulse alongside rx_done when parity mismatched
//   frame_err  : one-cycle pulse when the stop bit sampled 0
//   busy       : high whenever the FSM is not idle
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter bit          PARITY_EN    = 1'b0,
    parameter bit          PARITY_ODD   = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 rx_done,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    logic rx_s;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    uart_state_t          state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 armed_q, armed_d;
    logic                 mismatch_q, mismatch_d;
    logic                 done_q, done_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            armed_q    <= 1'b0;
            mismatch_q <= 1'b0;
            done_q     <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            armed_q    <= armed_d;
            mismatch_q <= mismatch_d;
            done_q     <= done_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        bit_d      = bit_q;
        shift_d    = shift_q;
        data_d     = data_q;
        armed_d    = armed_q;
        mismatch_d = mismatch_q;
        done_d     = 1'b0;
        perr_d     = 1'b0;
        ferr_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d      = '0;
                mismatch_d = 1'b0;
                // A line stuck low after a bad frame must go high before we re-arm.
                if (rx_s) begin
                    armed_d = 1'b1;
                end
                if (armed_q && !rx_s) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + 1'b1;  // wraps to 0 on the last bit
                    if (bit_q == BIT_LAST) begin
                        state_d = PARITY_EN ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d      = '0;
                    mismatch_d = ((^shift_q) ^ rx_s) != PARITY_ODD;
                    state_d    = STOP;
                end
            end
            STOP: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    armed_d = 1'b0;
                    state_d = IDLE;
                    if (rx_s) begin
                        data_d = shift_q;
                        done_d = 1'b1;
                        perr_d = mismatch_q & PARITY_EN;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign data_out   = data_q;
    assign rx_done    = done_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
module tb_uart_rx_byte;

    localparam int CPB = 16;

    typedef struct packed {
        logic       ferr;
        logic       perr;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_np = 1'b1;
    logic       rx_pe = 1'b1;
    logic [7:0] data_np, data_pe;
    logic       done_np, done_pe, perr_np, perr_pe, ferr_np, ferr_pe, busy_np, busy_pe;

    int total = 0;
    int bad   = 0;

    exp_t q_np[$];
    exp_t q_pe[$];

    logic prev_done_np = 1'b0, prev_ferr_np = 1'b0, prev_perr_np = 1'b0;
    logic prev_done_pe = 1'b0, prev_ferr_pe = 1'b0, prev_perr_pe = 1'b0;

    always #5 clk = ~clk;

    uart_rx_byte #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut_np (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx_np),
        .data_out   (data_np),
        .rx_done    (done_np),
        .parity_err (perr_np),
        .frame_err  (ferr_np),
        .busy       (busy_np)
    );

    uart_rx_byte #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_pe (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx_pe),
        .data_out   (data_pe),
        .rx_done    (done_pe),
        .parity_err (perr_pe),
        .frame_err  (ferr_pe),
        .busy       (busy_pe)
    );

    // Monitor: pops an expected entry for every strobe and checks pulse rules.
    task automatic mon(input bit sel, input logic done, input logic perr, input logic ferr,
                       input logic [7:0] data, input logic pdone, input logic pperr,
                       input logic pferr);
        exp_t e;
        string nm;
        nm = sel ? "pe" : "np";
        if (done || ferr) begin
            total++;
            if (sel ? (q_pe.size() == 0) : (q_np.size() == 0)) begin
                bad++;
                $display("FAIL %s unexpected strobe: got done=%0b ferr=%0b data=%02h, required none",
                         nm, done, ferr, data);
            end else begin
                e = sel ? q_pe.pop_front() : q_np.pop_front();
                if ({done, ferr, perr, data} != {~e.ferr, e.ferr, e.perr, e.data}) begin
                    bad++;
                    $display("FAIL %s frame: got done=%0b ferr=%0b perr=%0b data=%02h, required done=%0b ferr=%0b perr=%0b data=%02h",
                             nm, done, ferr, perr, data, ~e.ferr, e.ferr, e.perr, e.data);
                end
            end
        end else if (perr) begin
            total++;
            bad++;
            $display("FAIL %s parity_err without rx_done: got 1 required 0", nm);
        end
        if ((done && pdone) || (ferr && pferr) || (perr && pperr)) begin
            total++;
            bad++;
            $display("FAIL %s pulse width: got strobe high 2 cycles, required 1", nm);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(1'b0, done_np, perr_np, ferr_np, data_np, prev_done_np, prev_perr_np, prev_ferr_np);
            mon(1'b1, done_pe, perr_pe, ferr_pe, data_pe, prev_done_pe, prev_perr_pe, prev_ferr_pe);
        end
        prev_done_np = done_np; prev_perr_np = perr_np; prev_ferr_np = ferr_np;
        prev_done_pe = done_pe; prev_perr_pe = perr_pe; prev_ferr_pe = ferr_pe;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic drive(input bit sel, input logic v);
        if (sel) rx_pe = v;
        else     rx_np = v;
    endtask

    task automatic hold_bit(input bit sel, input logic v);
        drive(sel, v);
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send(input bit sel, input logic [7:0] b, input bit use_par, input bit par,
                        input bit stop);
        hold_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) hold_bit(sel, b[i]);
        if (use_par) hold_bit(sel, par);
        hold_bit(sel, stop);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((q_np.size() != 0 || q_pe.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (q_np.size() != 0 || q_pe.size() != 0) begin
            bad++;
            $display("FAIL %s drain: got pending np=%0d pe=%0d required 0 0",
                     name, q_np.size(), q_pe.size());
        end
        repeat (2 * CPB) @(negedge clk);
    endtask

    initial begin
        bit seen_busy;

        repeat (4) @(negedge clk);
        check("reset np", {20'd0, busy_np, done_np, perr_np, ferr_np, data_np}, 32'd0);
        check("reset pe", {20'd0, busy_pe, done_pe, perr_pe, ferr_pe, data_pe}, 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 1: single frame
        q_np.push_back('{ferr: 1'b0, perr: 1'b0, data: 8'hFA});
        send(1'b0, 8'hFA, 1'b0, 1'b0, 1'b1);
        drain("t1");
        check("t1 busy idle", {31'd0, busy_np}, 32'd0);

        // 2: back-to-back frames, no idle gap
        q_np.push_back('{ferr: 1'b0, perr: 1'b0, data: 8'hC8});
        q_np.push_back('{ferr: 1'b0, perr: 1'b0, data: 8'h00});
        send(1'b0, 8'hC8, 1'b0, 1'b0, 1'b1);
        send(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        drain("t2");

        // 3: short low glitch is a false start
        seen_busy = 1'b0;
        drive(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (busy_np) seen_busy = 1'b1;
        end
        drive(1'b0, 1'b1);
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (busy_np) seen_busy = 1'b1;
        end
        check("t3 busy seen", {31'd0, seen_busy}, 32'd1);
        check("t3 busy idle", {31'd0, busy_np}, 32'd0);
        drain("t3");

        // 4: stop bit 0 then break; data_out keeps 0x00 from frame 2
        q_np.push_back('{ferr: 1'b1, perr: 1'b0, data: 8'h00});
        send(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        check("t4 no restart in break", {31'd0, busy_np}, 32'd0);
        drive(1'b0, 1'b1);
        drain("t4");

        // 5: even parity, 0x03 has even ones so parity bit 1 is a mismatch
        q_pe.push_back('{ferr: 1'b0, perr: 1'b1, data: 8'h03});
        send(1'b1, 8'h03, 1'b1, 1'b1, 1'b1);
        drain("t5a");
        q_pe.push_back('{ferr: 1'b0, perr: 1'b0, data: 8'h03});
        send(1'b1, 8'h03, 1'b1, 1'b0, 1'b1);
        drain("t5b");

        // 6: reset in the middle of data bit 4
        hold_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) hold_bit(1'b0, i[0]);  // 0xA5 bits 0..3 = 1,0,1,0 reversed below
        drive(1'b0, 1'b0);
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t6 reset np", {20'd0, busy_np, done_np, perr_np, ferr_np, data_np}, 32'd0);
        drive(1'b0, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2 * CPB) @(negedge clk);
        q_np.push_back('{ferr: 1'b0, perr: 1'b0, data: 8'hA5});
        send(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
        drain("t6");
        check("t6 data held", {24'd0, data_np}, 32'hA5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
